keypad_time_entry: RTL and testbench

- Front-end of the microwave timer: turns raw keypad presses into a 3-digit BCD time (M:S S) and hands it to the mod-10/mod-6 down-counter chain.
- Presents the digits on the counters' data inputs and issues a one-cycle active-low load strobe on START.
- Debounces keys, rejects multi-key chords and invalid seconds, and supports a CANCEL key.
- Sits directly upstream of the timer counters; one instance per timer.

---
 rtl/keypad_time_entry.sv | 190 +++++++++++++++++++
 tb/tb_keypad_time_entry.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_time_entry.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_time_entry
//  Description : Keypad front-end for the microwave timer. Debounces single
//                key presses, shifts accepted digits into a 3-digit BCD time
//                (M:SS), validates it on a START edge and drives a one-cycle
//                active-low load strobe into the down-counter chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_time_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [9:0] keypad,
    input  logic       start,
    input  logic       cancel,
    input  logic       entry_en,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       loadn,
    output logic       key_ack,
    output logic       err,
    output logic [1:0] digit_cnt
);

    // Count value at which a stable key is accepted.
    localparam logic [CNT_W-1:0] c_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);
    // With a one-cycle debounce the first sample already completes the count.
    localparam bit               c_DEB_ONE  = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       key_idx_q;
    logic             start_q;

    logic [3:0]       mins_q;
    logic [3:0]       sec_tens_q;
    logic [3:0]       sec_ones_q;
    logic             loadn_q;
    logic             key_ack_q;
    logic             err_q;
    logic [1:0]       digit_cnt_q;

    logic             w_onehot;
    logic             w_same_key;
    logic [3:0]       w_key_enc;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_accept;
    logic             w_start_edge;
    logic             w_time_valid;

    // Key decode: one-hot detect and index of the pressed key.
    always_comb begin
        w_key_enc = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) begin
                w_key_enc = 4'(i);
            end
        end
        w_onehot   = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
        w_same_key = w_onehot && (w_key_enc == key_idx_q);
        w_cnt_inc  = cnt_q + CNT_W'(1);
    end

    // A digit is accepted on the edge where the stable count reaches its target.
    always_comb begin
        w_accept = 1'b0;
        if (entry_en) begin
            if (state_q == IDLE && w_onehot && c_DEB_ONE) begin
                w_accept = 1'b1;
            end else if (state_q == DEBOUNCE && w_same_key && w_cnt_inc == c_DEB_LAST) begin
                w_accept = 1'b1;
            end
        end
    end

    // START rising edge and load legality (seconds tens <= 5, time nonzero).
    always_comb begin
        w_start_edge = start & ~start_q;
        w_time_valid = (sec_tens_q <= 4'd5) &&
                       ({mins_q, sec_tens_q, sec_ones_q} != 12'd0);
    end

    // Key FSM: idle -> debounce -> held; one accept per press, no auto-repeat.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_idx_q <= 4'd0;
        end else if (!entry_en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_onehot) begin
                        key_idx_q <= w_key_enc;
                        cnt_q     <= CNT_W'(1);
                        state_q   <= c_DEB_ONE ? HELD : DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (w_same_key) begin
                        cnt_q <= w_cnt_inc;
                        if (w_cnt_inc == c_DEB_LAST) begin
                            state_q <= HELD;
                        end
                    end else begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                HELD: begin
                    if (keypad == 10'd0) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Digit register, load strobe and status pulses; cancel > start > accept.
    always_ff @(posedge clk) begin
        if (clr) begin
            start_q     <= 1'b0;
            mins_q      <= 4'd0;
            sec_tens_q  <= 4'd0;
            sec_ones_q  <= 4'd0;
            loadn_q     <= 1'b1;
            key_ack_q   <= 1'b0;
            err_q       <= 1'b0;
            digit_cnt_q <= 2'd0;
        end else begin
            start_q   <= start;
            loadn_q   <= 1'b1;
            key_ack_q <= 1'b0;
            err_q     <= 1'b0;
            if (cancel) begin
                mins_q      <= 4'd0;
                sec_tens_q  <= 4'd0;
                sec_ones_q  <= 4'd0;
                digit_cnt_q <= 2'd0;
            end else if (!loadn_q) begin
                // Strobe cycle done: counters have the time, clear the entry.
                mins_q      <= 4'd0;
                sec_tens_q  <= 4'd0;
                sec_ones_q  <= 4'd0;
                digit_cnt_q <= 2'd0;
            end else if (w_start_edge) begin
                if (w_time_valid) begin
                    loadn_q <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (w_accept) begin
                mins_q      <= sec_tens_q;
                sec_tens_q  <= sec_ones_q;
                sec_ones_q  <= key_idx_q;
                key_ack_q   <= 1'b1;
                if (digit_cnt_q != 2'd3) begin
                    digit_cnt_q <= digit_cnt_q + 2'd1;
                end
            end
        end
    end

    assign mins      = mins_q;
    assign sec_tens  = sec_tens_q;
    assign sec_ones  = sec_ones_q;
    assign loadn     = loadn_q;
    assign key_ack   = key_ack_q;
    assign err       = err_q;
    assign digit_cnt = digit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_time_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_time_entry
//  Description : Directed self-checking bench for keypad_time_entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_time_entry;

    logic       clk = 1'b0;
    logic       clr;
    logic [9:0] keypad;
    logic       start;
    logic       cancel;
    logic       entry_en;
    logic [3:0] mins;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       loadn;
    logic       key_ack;
    logic       err;
    logic [1:0] digit_cnt;

    int n_vec = 0;
    int n_mis = 0;
    int acks;
    int total_acks;
    logic load_seen;

    keypad_time_entry #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .keypad   (keypad),
        .start    (start),
        .cancel   (cancel),
        .entry_en (entry_en),
        .mins     (mins),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .loadn    (loadn),
        .key_ack  (key_ack),
        .err      (err),
        .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold a key mask for 'hold' cycles, release for 'rel' cycles, count acks.
    task automatic press(input logic [9:0] mask, input int hold, input int rel, output int n);
        n = 0;
        keypad = mask;
        repeat (hold) begin
            tick();
            if (key_ack === 1'b1) n++;
            if (loadn !== 1'b1) load_seen = 1'b1;
        end
        keypad = 10'd0;
        repeat (rel) begin
            tick();
            if (key_ack === 1'b1) n++;
            if (loadn !== 1'b1) load_seen = 1'b1;
        end
    endtask

    task automatic digit(input int d);
        int a;
        press(10'd1 << d, 6, 3, a);
        total_acks += a;
    endtask

    initial begin
        clr = 1'b1; keypad = 10'd0; start = 1'b0; cancel = 1'b0; entry_en = 1'b1;
        load_seen = 1'b0; total_acks = 0;
        tick(); tick();
        clr = 1'b0;

        // Reset state
        chk("rst_digits", {4'd0, mins, sec_tens, sec_ones}, 16'h0000);
        chk("rst_loadn", loadn, 1'b1);
        chk("rst_ack_err", {key_ack, err}, 2'b00);
        chk("rst_cnt", digit_cnt, 2'd0);

        // Enter 1,3,0
        digit(1); digit(3); digit(0);
        chk("e130_acks", total_acks, 3);
        chk("e130_digits", {mins, sec_tens, sec_ones}, 12'h130);
        chk("e130_cnt", digit_cnt, 2'd3);

        // Short press of 7 is rejected, long press accepted once
        press(10'd1 << 7, 2, 3, acks);
        chk("short7_acks", acks, 0);
        chk("short7_digits", {mins, sec_tens, sec_ones}, 12'h130);
        press(10'd1 << 7, 20, 3, acks);
        chk("long7_acks", acks, 1);
        chk("long7_digits", {mins, sec_tens, sec_ones}, 12'h307);
        chk("long7_cnt", digit_cnt, 2'd3);

        // Two-key chord is rejected
        press((10'd1 << 2) | (10'd1 << 5), 10, 3, acks);
        chk("chord_acks", acks, 0);
        chk("no_load_yet", load_seen, 1'b0);

        // Enter 4,5 and start: 7:4:5 loaded
        digit(4); digit(5);
        chk("e45_digits", {mins, sec_tens, sec_ones}, 12'h745);
        start = 1'b1;
        tick();
        chk("load_low", loadn, 1'b0);
        chk("load_digits", {mins, sec_tens, sec_ones}, 12'h745);
        tick();
        chk("load_done", loadn, 1'b1);
        chk("load_clear", {2'b00, digit_cnt, mins, sec_tens, sec_ones}, 16'h0000);
        start = 1'b0;
        tick();

        // Invalid seconds: err pulse, no load
        digit(9); digit(9);
        chk("e99_digits", {mins, sec_tens, sec_ones}, 12'h099);
        start = 1'b1;
        tick();
        chk("err_pulse", {err, loadn}, 2'b11);
        tick();
        chk("err_end", {err, loadn}, 2'b01);
        chk("err_keep", {mins, sec_tens, sec_ones}, 12'h099);
        start = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_clear", {2'b00, digit_cnt, mins, sec_tens, sec_ones}, 16'h0000);

        // Enter 1,2,3,4 then clr right after the start edge
        digit(1); digit(2); digit(3); digit(4);
        chk("e1234_digits", {mins, sec_tens, sec_ones}, 12'h234);
        chk("e1234_cnt", digit_cnt, 2'd3);
        start = 1'b1;
        tick();
        chk("pre_clr_load", loadn, 1'b0);
        clr = 1'b1; start = 1'b0;
        tick();
        clr = 1'b0;
        chk("clr_loadn", loadn, 1'b1);
        chk("clr_all", {1'b0, key_ack, err, digit_cnt, mins, sec_tens, sec_ones}, 16'h0000);

        // Entry disabled: no accept
        entry_en = 1'b0;
        press(10'd1 << 8, 10, 2, acks);
        entry_en = 1'b1;
        chk("dis_acks", acks, 0);
        chk("dis_digits", {2'b00, digit_cnt, mins, sec_tens, sec_ones}, 16'h0000);

        // Start and cancel together with 0:1:0
        digit(1); digit(0);
        chk("e10_digits", {mins, sec_tens, sec_ones}, 12'h010);
        start = 1'b1; cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("sc_loadn", {loadn, err}, 2'b10);
        chk("sc_clear", {2'b00, digit_cnt, mins, sec_tens, sec_ones}, 16'h0000);
        tick();
        chk("sc_loadn2", loadn, 1'b1);
        start = 1'b0;
        tick();

        // Boundary: sec_tens = 5 is legal
        digit(5); digit(9);
        start = 1'b1;
        tick();
        chk("st5_load", {loadn, err}, 2'b00);
        chk("st5_digits", {mins, sec_tens, sec_ones}, 12'h059);
        tick();
        chk("st5_done", {loadn, mins, sec_tens, sec_ones}, 13'h1000);
        start = 1'b0;
        tick();

        // Digit accepted on the same edge as a start edge is dropped
        digit(1);
        keypad = 10'd1 << 6;
        tick(); tick(); tick();
        start = 1'b1;
        tick();
        chk("drop_ack", {key_ack, loadn}, 2'b00);
        chk("drop_digits", {mins, sec_tens, sec_ones}, 12'h001);
        tick();
        chk("drop_done", {key_ack, loadn, mins, sec_tens, sec_ones}, 14'h1000);
        press(10'd1 << 6, 4, 3, acks);
        chk("drop_held_noack", acks, 0);
        start = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
